// File: rtl/router_pkt_sink.sv
// router_pkt_sink: consumer for one router output port.
//   Watches valid_out, issues read_enb, and reassembles a packet made of a
//   header byte ({len[5:0], addr[1:0]}), len payload bytes and a parity byte
//   (XOR of header and payload). Reports completion, parity/address errors,
//   truncation by timeout, and keeps packet/error counters.
// Parameters: EXP_ADDR (expected address), READ_DELAY (0..28 idle cycles
//   before the first read), TIMEOUT (1..63 starved cycles before abort).
// Ports:
//   clk, resetn             clock, async active-low reset
//   valid_out, data_out     router FIFO status / read data (data one cycle
//                           after read_enb)
//   read_enb                FIFO read strobe (combinational)
//   byte_vld, byte_data     payload byte pulse
//   hdr_len, hdr_addr       header fields, held until the next header
//   pkt_done                pulse after the parity byte is captured
//   parity_err, addr_err    packet status, valid with pkt_done
//   trunc_err               pulse when a packet is aborted by timeout
//   pkt_cnt, err_cnt        completed-packet count (wraps) / error count
//                           (saturates)
// Build option: define ROUTER_SINK_ERRCNT_EN to implement err_cnt; without
//   it err_cnt is tied to zero.
module router_pkt_sink #(
  parameter logic [1:0] EXP_ADDR   = 2'd0,
  parameter int         READ_DELAY = 0,
  parameter int         TIMEOUT    = 31
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic [5:0] hdr_len,
  output logic [1:0] hdr_addr,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       trunc_err,
  output logic [7:0] pkt_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DLY, RD, DONE} state_t;

  state_t     state;
  logic [4:0] dly_cnt;
  logic [6:0] issued, captured, limit, last_idx;
  logic [5:0] to_cnt;
  logic       rd_q;      // data_out holds a fresh byte this cycle
  logic [7:0] acc;
  logic       cap_last, to_fire;

  // Index of the parity byte; only meaningful once the header is in.
  assign last_idx = {1'b0, hdr_len} + 7'd1;
  // Until the header lands we only know the packet has at least 2 bytes,
  // which keeps a zero-length packet from over-reading.
  assign limit    = (captured == 7'd0) ? 7'd2 : last_idx + 7'd1;
  assign read_enb = (state == RD) && valid_out && (issued < limit);

  assign cap_last = (state == RD) && rd_q && (captured != 7'd0) &&
                    (captured == last_idx);
  // Completion wins over a coincident timeout.
  assign to_fire  = (state == RD) && !valid_out && !cap_last &&
                    (to_cnt == 6'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      issued     <= '0;
      captured   <= '0;
      to_cnt     <= '0;
      rd_q       <= 1'b0;
      acc        <= '0;
      byte_vld   <= 1'b0;
      byte_data  <= '0;
      hdr_len    <= '0;
      hdr_addr   <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      byte_vld  <= 1'b0;
      pkt_done  <= 1'b0;
      trunc_err <= 1'b0;
      rd_q      <= read_enb;
      case (state)
        IDLE: begin
          issued   <= '0;
          captured <= '0;
          to_cnt   <= '0;
          if (valid_out) begin
            if (READ_DELAY == 0) begin
              state <= RD;
            end else begin
              state   <= DLY;
              dly_cnt <= 5'(READ_DELAY);
            end
          end
        end
        // Leaving on a count of 1 makes DLY last exactly READ_DELAY cycles.
        DLY: begin
          if (dly_cnt <= 5'd1) state <= RD;
          else                 dly_cnt <= dly_cnt - 5'd1;
        end
        RD: begin
          if (read_enb) issued <= issued + 7'd1;
          to_cnt <= valid_out ? 6'd0 : to_cnt + 6'd1;
          if (rd_q) begin
            captured <= captured + 7'd1;
            if (captured == 7'd0) begin
              hdr_len    <= data_out[7:2];
              hdr_addr   <= data_out[1:0];
              acc        <= data_out;
              parity_err <= 1'b0;
              addr_err   <= 1'b0;
            end else if (!cap_last) begin
              acc       <= acc ^ data_out;
              byte_vld  <= 1'b1;
              byte_data <= data_out;
            end else begin
              parity_err <= (acc != data_out);
              addr_err   <= (hdr_addr != EXP_ADDR);
              pkt_done   <= 1'b1;
              state      <= DONE;
            end
          end
          if (to_fire) begin
            trunc_err <= 1'b1;
            state     <= IDLE;
          end
        end
        DONE: begin
          pkt_cnt <= pkt_cnt + 8'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_SINK_ERRCNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_cnt <= '0;
    else if (((state == DONE) && (parity_err || addr_err)) || to_fire)
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_router_pkt_sink.sv
// Bench for router_pkt_sink: a FIFO model feeds two sinks (READ_DELAY 0 and
// 4, EXP_ADDR 2); expected values come from packet-level rules.
module tb_router_pkt_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       valid_v[2];
  logic [7:0] data_v[2];
  logic       rd_v[2], bv_v[2], done_v[2], perr_v[2], aerr_v[2], trunc_v[2];
  logic [7:0] bd_v[2], pc_v[2], ec_v[2];
  logic [5:0] hl_v[2];
  logic [1:0] ha_v[2];

  router_pkt_sink #(.EXP_ADDR(2'd2), .READ_DELAY(0), .TIMEOUT(31)) dut0 (
    .clk(clk), .resetn(resetn), .valid_out(valid_v[0]), .data_out(data_v[0]),
    .read_enb(rd_v[0]), .byte_vld(bv_v[0]), .byte_data(bd_v[0]),
    .hdr_len(hl_v[0]), .hdr_addr(ha_v[0]), .pkt_done(done_v[0]),
    .parity_err(perr_v[0]), .addr_err(aerr_v[0]), .trunc_err(trunc_v[0]),
    .pkt_cnt(pc_v[0]), .err_cnt(ec_v[0]));

  router_pkt_sink #(.EXP_ADDR(2'd2), .READ_DELAY(4), .TIMEOUT(31)) dut1 (
    .clk(clk), .resetn(resetn), .valid_out(valid_v[1]), .data_out(data_v[1]),
    .read_enb(rd_v[1]), .byte_vld(bv_v[1]), .byte_data(bd_v[1]),
    .hdr_len(hl_v[1]), .hdr_addr(ha_v[1]), .pkt_done(done_v[1]),
    .parity_err(perr_v[1]), .addr_err(aerr_v[1]), .trunc_err(trunc_v[1]),
    .pkt_cnt(pc_v[1]), .err_cnt(ec_v[1]));

`ifdef ROUTER_SINK_ERRCNT_EN
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int m_pkt[2];
  int m_err[2];

  logic [7:0] fifo[$];
  logic [7:0] e_bytes[$];
  logic [7:0] o_bytes[$];
  int         o_done[$];
  bit         o_perr[$], o_aerr[$];
  int         o_reads, o_first_rd, o_gap_reads, o_trunc_n, o_trunc_cyc;

  function automatic int exp_err(input int s);
    return ERRC ? m_err[s] : 0;
  endfunction

  function automatic int bytes_bad();
    int bad = 0;
    if (o_bytes.size() != e_bytes.size()) return 999;
    foreach (e_bytes[i]) if (o_bytes[i] !== e_bytes[i]) bad++;
    return bad;
  endfunction

  // Header {len,addr}, len random payload bytes, parity = XOR of all before it.
  task automatic build(input logic [5:0] len, input logic [1:0] addr,
                       input bit corrupt);
    logic [7:0] h, p, b;
    h = {len, addr};
    p = h;
    fifo.push_back(h);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      fifo.push_back(b);
      e_bytes.push_back(b);
      p ^= b;
    end
    fifo.push_back(corrupt ? (p ^ 8'h01) : p);
  endtask

  // Cycle 0 is the first cycle valid_out is high. FIFO data appears the
  // cycle after a read. Optional starvation gap after gap_after pops.
  task automatic run(input int s, input int ncyc, input int gap_after,
                     input int gap_len, input bit flush_gap);
    int   pops = 0;
    int   gap_rem = 0;
    bit   gapped = 0;
    logic rd;
    o_bytes.delete(); o_done.delete(); o_perr.delete(); o_aerr.delete();
    o_reads = 0; o_first_rd = -1; o_gap_reads = 0;
    o_trunc_n = 0; o_trunc_cyc = -1;
    valid_v[s] = (fifo.size() > 0);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rd = rd_v[s];
      if (rd) begin
        o_reads++;
        if (o_first_rd < 0) o_first_rd = c;
        if (!valid_v[s]) o_gap_reads++;
      end
      if (bv_v[s]) o_bytes.push_back(bd_v[s]);
      if (done_v[s]) begin
        o_done.push_back(c);
        o_perr.push_back(perr_v[s]);
        o_aerr.push_back(aerr_v[s]);
      end
      if (trunc_v[s]) begin o_trunc_n++; o_trunc_cyc = c; end
      @(posedge clk); #1;
      if (rd) begin
        data_v[s] = (fifo.size() > 0) ? fifo.pop_front() : 8'h00;
        pops++;
      end
      if (gap_rem > 0) begin
        gap_rem--;
        if (gap_rem == 0 && flush_gap) fifo.delete();
      end else if (!gapped && gap_len > 0 && pops == gap_after) begin
        gapped = 1; gap_rem = gap_len;
      end
      valid_v[s] = (fifo.size() > 0) && (gap_rem == 0);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      m_pkt[s] = 0; m_err[s] = 0;
      checks++;
      if ({rd_v[s], bv_v[s], done_v[s], perr_v[s], aerr_v[s], trunc_v[s],
           bd_v[s], hl_v[s], ha_v[s], pc_v[s], ec_v[s]} !== 38'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h, expected 0", s,
          {rd_v[s], bv_v[s], done_v[s], perr_v[s], aerr_v[s], trunc_v[s],
           bd_v[s], hl_v[s], ha_v[s], pc_v[s], ec_v[s]});
      end
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    e_bytes.delete();
    build(6'd5, 2'd2, 1'b0);
    run(0, 14, 0, 0, 0);
    m_pkt[0]++;
    checks++; if (o_reads !== 7) begin errors++; $display("FAIL basic_reads: got %0d, expected 7", o_reads); end
    checks++; if (o_first_rd !== 1) begin errors++; $display("FAIL basic_first_rd: got %0d, expected 1", o_first_rd); end
    checks++; if (bytes_bad() !== 0) begin errors++; $display("FAIL basic_bytes: got %0d bad of %0d, expected 0", bytes_bad(), o_bytes.size()); end
    checks++; if (o_done.size() !== 1 || o_done[0] !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d (n=%0d), expected 9", (o_done.size() > 0) ? o_done[0] : -1, o_done.size()); end
    checks++; if (o_done.size() !== 1 || o_perr[0] !== 1'b0 || o_aerr[0] !== 1'b0) begin errors++; $display("FAIL basic_errs: got n=%0d, expected perr=0 aerr=0", o_done.size()); end
    checks++; if ({hl_v[0], ha_v[0]} !== 8'h16) begin errors++; $display("FAIL basic_hdr: got %h, expected 16", {hl_v[0], ha_v[0]}); end
    checks++; if (int'(pc_v[0]) !== m_pkt[0] || int'(ec_v[0]) !== exp_err(0)) begin errors++; $display("FAIL basic_cnt: got %0d/%0d, expected %0d/%0d", pc_v[0], ec_v[0], m_pkt[0], exp_err(0)); end
  endtask

  task automatic test_parity_err();
    e_bytes.delete();
    build(6'd5, 2'd2, 1'b1);
    run(0, 14, 0, 0, 0);
    m_pkt[0]++; m_err[0]++;
    checks++; if (o_done.size() !== 1 || o_perr[0] !== 1'b1 || o_aerr[0] !== 1'b0) begin errors++; $display("FAIL parity_flag: got n=%0d, expected perr=1 aerr=0", o_done.size()); end
    checks++; if (int'(pc_v[0]) !== m_pkt[0] || int'(ec_v[0]) !== exp_err(0)) begin errors++; $display("FAIL parity_cnt: got %0d/%0d, expected %0d/%0d", pc_v[0], ec_v[0], m_pkt[0], exp_err(0)); end
  endtask

  task automatic test_addr_and_zero();
    e_bytes.delete();
    build(6'd2, 2'd1, 1'b0);   // header 8'h09
    run(0, 12, 0, 0, 0);
    m_pkt[0]++; m_err[0]++;
    checks++; if (o_done.size() !== 1 || o_aerr[0] !== 1'b1 || o_perr[0] !== 1'b0) begin errors++; $display("FAIL addr_flag: got n=%0d, expected aerr=1 perr=0", o_done.size()); end
    e_bytes.delete();
    build(6'd0, 2'd0, 1'b0);   // header 8'h00, address also mismatches
    run(0, 10, 0, 0, 0);
    m_pkt[0]++; m_err[0]++;
    checks++; if (o_reads !== 2) begin errors++; $display("FAIL zero_reads: got %0d, expected 2", o_reads); end
    checks++; if (o_done.size() !== 1 || o_done[0] !== 4) begin errors++; $display("FAIL zero_done_cycle: got %0d (n=%0d), expected 4", (o_done.size() > 0) ? o_done[0] : -1, o_done.size()); end
    checks++; if (o_bytes.size() !== 0) begin errors++; $display("FAIL zero_bytes: got %0d, expected 0", o_bytes.size()); end
    checks++; if (int'(pc_v[0]) !== m_pkt[0] || int'(ec_v[0]) !== exp_err(0)) begin errors++; $display("FAIL zero_cnt: got %0d/%0d, expected %0d/%0d", pc_v[0], ec_v[0], m_pkt[0], exp_err(0)); end
  endtask

  task automatic test_gap();
    e_bytes.delete();
    build(6'd5, 2'd2, 1'b0);
    run(0, 26, 3, 10, 0);
    m_pkt[0]++;
    checks++; if (o_reads !== 7 || o_gap_reads !== 0) begin errors++; $display("FAIL gap_reads: got %0d/%0d, expected 7/0", o_reads, o_gap_reads); end
    checks++; if (bytes_bad() !== 0) begin errors++; $display("FAIL gap_bytes: got %0d bad, expected 0", bytes_bad()); end
    checks++; if (o_done.size() !== 1 || o_done[0] !== 19 || o_perr[0] !== 1'b0) begin errors++; $display("FAIL gap_done: got %0d (n=%0d), expected 19", (o_done.size() > 0) ? o_done[0] : -1, o_done.size()); end
  endtask

  task automatic test_timeout();
    e_bytes.delete();
    build(6'd5, 2'd2, 1'b0);
    run(0, 45, 3, 31, 1);
    m_err[0]++;
    checks++; if (o_trunc_n !== 1 || o_trunc_cyc !== 35) begin errors++; $display("FAIL trunc_pulse: got n=%0d at %0d, expected 1 at 35", o_trunc_n, o_trunc_cyc); end
    checks++; if (o_done.size() !== 0) begin errors++; $display("FAIL trunc_no_done: got %0d, expected 0", o_done.size()); end
    checks++; if (int'(pc_v[0]) !== m_pkt[0] || int'(ec_v[0]) !== exp_err(0)) begin errors++; $display("FAIL trunc_cnt: got %0d/%0d, expected %0d/%0d", pc_v[0], ec_v[0], m_pkt[0], exp_err(0)); end
    // Sink must be back in IDLE: a fresh packet starts with no delay.
    e_bytes.delete();
    build(6'd3, 2'd2, 1'b0);
    run(0, 12, 0, 0, 0);
    m_pkt[0]++;
    checks++; if (o_first_rd !== 1 || o_done.size() !== 1 || o_done[0] !== 7 || bytes_bad() !== 0) begin errors++; $display("FAIL trunc_recover: got first=%0d ndone=%0d bad=%0d, expected 1/1/0", o_first_rd, o_done.size(), bytes_bad()); end
  endtask

  task automatic test_back_to_back();
    int l1, l2;
    l1 = $urandom_range(0, 10);
    l2 = $urandom_range(0, 10);
    e_bytes.delete();
    build(6'(l1), 2'd2, 1'b0);
    build(6'(l2), 2'd2, 1'b0);
    run(0, l1 + l2 + 16, 0, 0, 0);
    m_pkt[0] += 2;
    checks++; if (o_reads !== l1 + l2 + 4) begin errors++; $display("FAIL b2b_reads: got %0d, expected %0d", o_reads, l1 + l2 + 4); end
    checks++; if (o_done.size() !== 2 || o_done[0] !== l1 + 4 || o_done[1] !== l1 + l2 + 9) begin errors++; $display("FAIL b2b_done: got n=%0d, expected %0d,%0d", o_done.size(), l1 + 4, l1 + l2 + 9); end
    checks++; if (bytes_bad() !== 0) begin errors++; $display("FAIL b2b_bytes: got %0d bad, expected 0", bytes_bad()); end
    checks++; if (int'(pc_v[0]) !== m_pkt[0]) begin errors++; $display("FAIL b2b_cnt: got %0d, expected %0d", pc_v[0], m_pkt[0]); end
  endtask

  task automatic test_random();
    int         len;
    logic [1:0] addr;
    bit         cor, ea;
    for (int i = 0; i < 8; i++) begin
      len  = $urandom_range(0, 20);
      addr = 2'($urandom);
      cor  = 1'($urandom);
      ea   = (addr != 2'd2);
      e_bytes.delete();
      build(6'(len), addr, cor);
      run(0, len + 8, 0, 0, 0);
      m_pkt[0]++;
      if (cor || ea) m_err[0]++;
      checks++; if (o_reads !== len + 2 || o_first_rd !== 1) begin errors++; $display("FAIL rnd_reads[%0d]: got %0d first %0d, expected %0d first 1", i, o_reads, o_first_rd, len + 2); end
      checks++; if (bytes_bad() !== 0) begin errors++; $display("FAIL rnd_bytes[%0d]: got %0d bad, expected 0", i, bytes_bad()); end
      checks++; if (o_done.size() !== 1 || o_done[0] !== len + 4 || o_perr[0] !== cor || o_aerr[0] !== ea) begin errors++; $display("FAIL rnd_done[%0d]: got n=%0d, expected at %0d perr=%0d aerr=%0d", i, o_done.size(), len + 4, cor, ea); end
      checks++; if (int'(pc_v[0]) !== m_pkt[0] || int'(ec_v[0]) !== exp_err(0)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d, expected %0d/%0d", i, pc_v[0], ec_v[0], m_pkt[0], exp_err(0)); end
    end
  endtask

  task automatic test_read_delay();
    int len;
    len = $urandom_range(1, 12);
    e_bytes.delete();
    build(6'(len), 2'd2, 1'b0);
    run(1, len + 12, 0, 0, 0);
    m_pkt[1]++;
    checks++; if (o_first_rd !== 5) begin errors++; $display("FAIL dly_first_rd: got %0d, expected 5", o_first_rd); end
    checks++; if (o_done.size() !== 1 || o_done[0] !== len + 8 || o_perr[0] !== 1'b0) begin errors++; $display("FAIL dly_done: got n=%0d, expected at %0d", o_done.size(), len + 8); end
    checks++; if (bytes_bad() !== 0 || int'(pc_v[1]) !== m_pkt[1]) begin errors++; $display("FAIL dly_bytes_cnt: got bad=%0d cnt=%0d, expected 0/%0d", bytes_bad(), pc_v[1], m_pkt[1]); end
  endtask

  task automatic test_reset_mid();
    e_bytes.delete();
    build(6'd6, 2'd2, 1'b0);
    run(0, 5, 0, 0, 0);       // stops mid-payload
    resetn = 1'b0;
    #1;
    m_pkt[0] = 0; m_err[0] = 0; m_pkt[1] = 0; m_err[1] = 0;
    checks++;
    if ({rd_v[0], bv_v[0], done_v[0], perr_v[0], aerr_v[0], trunc_v[0],
         bd_v[0], hl_v[0], ha_v[0], pc_v[0], ec_v[0]} !== 38'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h, expected 0",
        {rd_v[0], bv_v[0], done_v[0], perr_v[0], aerr_v[0], trunc_v[0],
         bd_v[0], hl_v[0], ha_v[0], pc_v[0], ec_v[0]});
    end
    fifo.delete();
    valid_v[0] = 1'b0;
    data_v[0]  = 8'h00;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    e_bytes.delete();
    build(6'd4, 2'd2, 1'b0);
    run(0, 12, 0, 0, 0);
    m_pkt[0]++;
    checks++; if (o_done.size() !== 1 || o_done[0] !== 8 || o_perr[0] !== 1'b0 || o_aerr[0] !== 1'b0 || bytes_bad() !== 0) begin errors++; $display("FAIL reset_mid_next: got n=%0d bad=%0d, expected clean packet at 8", o_done.size(), bytes_bad()); end
    checks++; if (int'(pc_v[0]) !== m_pkt[0] || int'(ec_v[0]) !== exp_err(0)) begin errors++; $display("FAIL reset_mid_cnt: got %0d/%0d, expected %0d/%0d", pc_v[0], ec_v[0], m_pkt[0], exp_err(0)); end
  endtask

  initial begin
    valid_v[0] = 1'b0; valid_v[1] = 1'b0;
    data_v[0]  = 8'h00; data_v[1]  = 8'h00;
    test_reset();
    test_basic();
    test_parity_err();
    test_addr_and_zero();
    test_gap();
    test_timeout();
    test_back_to_back();
    test_random();
    test_read_delay();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
